// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, ALU op encodings and control bundle
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational instruction decode producing control bundle and destination
module id_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  dst,
    output logic [31:0] imm,
    output logic        reads_rt,
    output logic        illegal
);

    // Shift amount is not used by any supported instruction.
    logic unused_shamt;
    assign unused_shamt = &{1'b0, instr[10:6]};

    always_comb begin
        ctrl     = CTRL_NONE;
        dst      = 5'd0;
        reads_rt = 1'b0;
        illegal  = 1'b0;
        imm      = sign_ext16(instr[15:0]);
        case (instr[31:26])
            OP_RTYPE: begin
                reads_rt       = 1'b1;
                dst            = instr[15:11];
                ctrl.reg_write = 1'b1;
                case (instr[5:0])
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl    = CTRL_NONE;
                        dst     = 5'd0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dst             = instr[20:16];
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                reads_rt       = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                reads_rt    = 1'b1;
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = 1'b1;
            end
            OP_ADDI: begin
                dst            = instr[20:16];
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard stall; ID_WB_BYPASS_EN adds WB->ID bypass
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    input  logic [31:0]         id_pc4,
    input  logic [31:0]         rd_data1,
    input  logic [31:0]         rd_data2,
    input  logic                wb_reg_write,
    input  logic [4:0]          wb_rd,
    input  logic [31:0]         wb_data,
    input  logic                ex_flush,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic                stall,
    output logic                ex_valid,
    output logic [31:0]         ex_a,
    output logic [31:0]         ex_b,
    output logic [31:0]         ex_imm,
    output logic [31:0]         ex_pc4,
    output logic [4:0]          ex_rs,
    output logic [4:0]          ex_rt,
    output logic [4:0]          ex_dst,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_mem_to_reg,
    output logic                ex_branch,
    output logic                illegal,
    output logic [15:0]         bubble_cnt
);

    ctrl_t       dec_ctrl;
    logic [4:0]  dec_dst;
    logic [31:0] dec_imm;
    logic        dec_reads_rt;
    logic        dec_illegal;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hazard;
    logic        load_bubble;
    ctrl_t       ctrl_n;
    logic [4:0]  dst_n;

    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];

    id_decode u_decode (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .dst      (dec_dst),
        .imm      (dec_imm),
        .reads_rt (dec_reads_rt),
        .illegal  (dec_illegal)
    );

`ifdef ID_WB_BYPASS_EN
    // Register file writes at the same edge it is read, so forward the writeback value here.
    assign op_a = (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) ? wb_data : rd_data1;
    assign op_b = (wb_reg_write && wb_rd != 5'd0 && wb_rd == rt) ? wb_data : rd_data2;
`else
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_reg_write, wb_rd, wb_data};
    assign op_a = rd_data1;
    assign op_b = rd_data2;
`endif

    assign hazard = ex_valid && ex_mem_read && (ex_dst != 5'd0) &&
                    ((ex_dst == rs) || ((ex_dst == rt) && dec_reads_rt));
    assign stall = !rst && id_valid && hazard && !ex_flush;

    assign load_bubble = ex_flush || stall || !id_valid || dec_illegal;
    assign ctrl_n      = load_bubble ? CTRL_NONE : dec_ctrl;
    assign dst_n       = load_bubble ? 5'd0 : dec_dst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
            ex_alu_op     <= '0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            illegal       <= 1'b0;
            bubble_cnt    <= '0;
        end else begin
            // Data fields are captured even for bubbles so they stay deterministic.
            ex_a          <= op_a;
            ex_b          <= op_b;
            ex_imm        <= dec_imm;
            ex_pc4        <= id_pc4;
            ex_rs         <= rs;
            ex_rt         <= rt;
            ex_valid      <= !load_bubble;
            ex_dst        <= dst_n;
            ex_alu_op     <= ALU_OP_W'(ctrl_n.alu_op);
            ex_alu_src    <= ctrl_n.alu_src;
            ex_reg_write  <= ctrl_n.reg_write;
            ex_mem_read   <= ctrl_n.mem_read;
            ex_mem_write  <= ctrl_n.mem_write;
            ex_mem_to_reg <= ctrl_n.mem_to_reg;
            ex_branch     <= ctrl_n.branch;
            // A stalled illegal instruction is re-presented, so report it only when it leaves ID.
            illegal       <= id_valid && dec_illegal && !ex_flush && !stall;
            if (stall && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc4 = '0;
    logic [31:0] rd_data1 = '0;
    logic [31:0] rd_data2 = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_flush = 1'b0;
    logic [4:0]  rs, rt, ex_rs, ex_rt, ex_dst;
    logic        stall, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read;
    logic        ex_mem_write, ex_mem_to_reg, ex_branch, illegal;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
    logic [3:0]  ex_alu_op;
    logic [15:0] bubble_cnt;

    id_ex_stage #(.ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush), .rs(rs), .rt(rt),
        .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .illegal(illegal),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] a, b, imm, pc4;
        logic [4:0]  rs, rt, dst;
        logic [3:0]  op;
        logic [5:0]  ctl;
        logic        ill;
        logic [15:0] bcnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc4 = 32'h1000;

    // ctl bit order: {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
    localparam logic [5:0] C_R   = 6'b010000;
    localparam logic [5:0] C_LW  = 6'b111010;
    localparam logic [5:0] C_SW  = 6'b100100;
    localparam logic [5:0] C_BEQ = 6'b000001;
    localparam logic [5:0] C_AI  = 6'b110000;
    localparam logic [5:0] C_0   = 6'b000000;

    localparam logic [31:0] I_ADD   = 32'h00221820;
    localparam logic [31:0] I_LW    = 32'h8C240008;
    localparam logic [31:0] I_ADD45 = 32'h00822820;
    localparam logic [31:0] I_SW    = 32'hAC240000;
    localparam logic [31:0] I_ILL   = 32'hFC000000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        chk("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(e.valid));
            chk("ex_a", ex_a, e.a);
            chk("ex_b", ex_b, e.b);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_pc4", ex_pc4, e.pc4);
            chk("ex_rs", 32'(ex_rs), 32'(e.rs));
            chk("ex_rt", 32'(ex_rt), 32'(e.rt));
            chk("ex_dst", 32'(ex_dst), 32'(e.dst));
            chk("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
            chk("ex_ctl", 32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                               ex_mem_to_reg, ex_branch}), 32'(e.ctl));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bcnt));
        end
    endtask

    task automatic step(input logic [31:0] instr, input logic v, input logic fl,
                        input logic [31:0] d1, input logic [31:0] d2, input logic e_stall,
                        input logic e_valid, input logic [4:0] e_dst, input logic [3:0] e_op,
                        input logic [5:0] e_ctl, input logic e_ill, input logic [15:0] e_bcnt);
        exp_t e;
        @(negedge clk);
        id_instr = instr; id_valid = v; ex_flush = fl;
        rd_data1 = d1; rd_data2 = d2;
        pc4 = pc4 + 32'd4; id_pc4 = pc4;
        #1;
        chk("stall", 32'(stall), 32'(e_stall));
        chk("rs", 32'(rs), 32'(instr[25:21]));
        chk("rt", 32'(rt), 32'(instr[20:16]));
        e.valid = e_valid;
        e.a     = (BYP && wb_reg_write && wb_rd != 5'd0 && wb_rd == instr[25:21]) ? wb_data : d1;
        e.b     = (BYP && wb_reg_write && wb_rd != 5'd0 && wb_rd == instr[20:16]) ? wb_data : d2;
        e.imm   = {{16{instr[15]}}, instr[15:0]};
        e.pc4   = pc4;
        e.rs    = instr[25:21];
        e.rt    = instr[20:16];
        e.dst   = e_dst;
        e.op    = e_op;
        e.ctl   = e_ctl;
        e.ill   = e_ill;
        e.bcnt  = e_bcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic rst_step(input logic [31:0] instr);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; id_instr = instr; id_valid = 1'b1; ex_flush = 1'b0;
        #1;
        chk("stall_in_rst", 32'(stall), 32'd0);
        e = '{valid: 1'b0, a: '0, b: '0, imm: '0, pc4: '0, rs: '0, rt: '0, dst: '0,
              op: '0, ctl: '0, ill: 1'b0, bcnt: '0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
        rst = 1'b0;
    endtask

    initial begin
        rst_step(I_ADD);
        //   instr         v  fl d1     d2   stall val dst op ctl    ill bcnt
        step(I_ADD,        1, 0, 5,     7,   0,    1,  3,  0, C_R,   0,  0);
        step(I_LW,         1, 0, 10,    0,   0,    1,  4,  0, C_LW,  0,  0);
        step(I_ADD45,      1, 0, 1,     2,   1,    0,  0,  0, C_0,   0,  1);
        step(I_ADD45,      1, 0, 3,     4,   0,    1,  5,  0, C_R,   0,  1);
        step(I_LW,         1, 0, 10,    0,   0,    1,  4,  0, C_LW,  0,  1);
        step(I_ADD45,      1, 1, 3,     4,   0,    0,  0,  0, C_0,   0,  1);
        step(I_LW,         1, 0, 10,    0,   0,    1,  4,  0, C_LW,  0,  1);
        step(I_SW,         1, 0, 6,     8,   1,    0,  0,  0, C_0,   0,  2);
        step(I_SW,         1, 0, 6,     9,   0,    1,  0,  0, C_SW,  0,  2);
        step(I_LW,         1, 0, 10,    0,   0,    1,  4,  0, C_LW,  0,  2);
        step(32'h20240001, 1, 0, 11,    12,  0,    1,  4,  0, C_AI,  0,  2);
        step(32'h2002FFFF, 1, 0, 0,     0,   0,    1,  2,  0, C_AI,  0,  2);
        step(32'h10220003, 1, 0, 1,     1,   0,    1,  0,  1, C_BEQ, 0,  2);
        step(32'h00221822, 1, 0, 9,     4,   0,    1,  3,  1, C_R,   0,  2);
        step(32'h00221824, 1, 0, 9,     4,   0,    1,  3,  2, C_R,   0,  2);
        step(32'h00221825, 1, 0, 9,     4,   0,    1,  3,  3, C_R,   0,  2);
        step(32'h0022182A, 1, 0, 9,     4,   0,    1,  3,  4, C_R,   0,  2);
        wb_reg_write = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        step(I_ADD,        1, 0, 0,     7,   0,    1,  3,  0, C_R,   0,  2);
        wb_rd = 5'd0;
        step(I_ADD,        1, 0, 0,     7,   0,    1,  3,  0, C_R,   0,  2);
        wb_reg_write = 1'b0; wb_data = '0;
        step(I_ILL,        1, 0, 1,     2,   0,    0,  0,  0, C_0,   1,  2);
        step(I_ADD,        0, 0, 1,     2,   0,    0,  0,  0, C_0,   0,  2);
        step(32'h00221821, 1, 0, 1,     2,   0,    0,  0,  0, C_0,   1,  2);
        step(I_ILL,        1, 1, 1,     2,   0,    0,  0,  0, C_0,   0,  2);
        step(I_LW,         1, 0, 10,    0,   0,    1,  4,  0, C_LW,  0,  2);
        rst_step(I_ADD45);
        step(I_ADD,        1, 0, 5,     7,   0,    1,  3,  0, C_R,   0,  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, width of ex_alu_op.
REQ-002 SHALL have ports: clk in 1 rising-edge clock; rst in 1 synchronous active-high reset.
REQ-003 SHALL have inputs: id_valid 1 IF/ID holds a valid instruction; id_instr 32 instruction; id_pc4 32 PC+4; rd_data1 32, rd_data2 32 register-file read data for rs/rt.
REQ-004 SHALL have inputs: wb_reg_write 1, wb_rd 5, wb_data 32 writeback port (same values driven to the register-file write port); ex_flush 1 taken branch resolved in EX.
REQ-005 SHALL have outputs: rs 5, rt 5 register-file read addresses (combinational from id_instr[25:21], id_instr[20:16]); stall 1 hold PC and IF/ID.
REQ-006 SHALL have registered outputs: ex_valid 1; ex_a 32; ex_b 32; ex_imm 32 sign-extended; ex_pc4 32; ex_rs 5; ex_rt 5; ex_dst 5; ex_alu_op ALU_OP_W; ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch each 1; illegal 1; bubble_cnt 16.

Function
REQ-007 SHALL decode: R-type (op 0) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; lw 0x23; sw 0x2B; beq 0x04; addi 0x08; all else illegal.
REQ-008 SHALL set ex_dst = rd for R-type, rt for lw/addi, 0 for sw/beq; ex_reg_write only for R-type, lw, addi.
REQ-009 SHALL detect load-use hazard when ex_valid & ex_mem_read & ex_dst!=0 & (ex_dst==rs | (ex_dst==rt & instruction reads rt: R-type, sw, beq)).
REQ-010 SHALL drive stall combinationally = id_valid & hazard & ~ex_flush.
REQ-011 SHALL on each clock edge: if ex_flush or stall or ~id_valid or illegal decode, load a bubble (ex_valid=0, all control bits 0, ex_dst=0); else capture decoded instruction with ex_valid=1.
REQ-012 SHALL keep data fields (ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt) of a bubble don't-care but deterministic (captured as normal).
REQ-013 SHALL pulse illegal for exactly one cycle in the cycle after an illegal instruction with id_valid=1 is presented and not flushed.
REQ-014 SHALL guarantee ex_flush has priority over stall and illegal in the same cycle (no stall, no illegal pulse).
REQ-015 SHALL increment bubble_cnt on each edge a stall-induced bubble is inserted, saturating at 0xFFFF.
REQ-016 SHALL hold one cycle latency ID->EX; a stalled instruction SHALL be re-presented unchanged by IF/ID and captured the following cycle.

Reset
REQ-017 SHALL on rst=1 at a clock edge clear every registered output to 0 (ex_valid=0, illegal=0, bubble_cnt=0); rst overrides ex_flush and stall.
REQ-018 SHALL drive stall=0 while rst=1.

Configuration
REQ-019 SHALL with macro ID_WB_BYPASS_EN defined substitute wb_data for rd_data1 (rd_data2) when wb_reg_write & wb_rd!=0 & wb_rd==rs (rt), compensating for the register file writing at the same edge it is read.
REQ-020 SHALL without ID_WB_BYPASS_EN pass rd_data1/rd_data2 unmodified (writeback-then-read requires one extra cycle, handled by software).

Structure
REQ-021 SHALL place opcode/funct constants, ALU op encodings (ADD 0, SUB 1, AND 2, OR 3, SLT 4) and the control-bundle struct in shared package mips_pkg.
REQ-022 SHALL implement decode as combinational sub-module id_decode; hazard, bypass and pipeline register in id_ex_stage.

Verification
REQ-023 SHALL test: add $3,$1,$2 (0x00221820), id_valid=1, rd_data1=5, rd_data2=7 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_dst=3, ex_alu_op=0, ex_reg_write=1.
REQ-024 SHALL test: lw $4,8($1) then add $5,$4,$2 -> stall=1 one cycle, bubble in EX, bubble_cnt=1, add captured next cycle.
REQ-025 SHALL test: stall condition with ex_flush=1 same cycle -> stall=0, bubble loaded, bubble_cnt unchanged.
REQ-026 SHALL test (ID_WB_BYPASS_EN): wb_reg_write=1, wb_rd=1, wb_data=0x1234, rs=1, rd_data1=0 -> ex_a=0x1234; wb_rd=0 -> ex_a=rd_data1.
REQ-027 SHALL test: opcode 0x3F with id_valid=1 -> illegal=1 one cycle, ex_valid=0; rst mid-stream -> all outputs 0 next edge.
REQ-028 SHALL test: addi $2,$0,-1 (0x2002FFFF) -> ex_imm=0xFFFFFFFF, ex_alu_src=1, ex_dst=2.
